// File: rtl/quan_cbr_tile_sequencer.sv
// quan_cbr_tile_sequencer: per-tile accumulate/drain/post-pipeline control for the quantised Conv-BN-ReLU kernel
module quan_cbr_tile_sequencer #(
   parameter int SA_ROWS     = 16,
   parameter int SA_SKEW     = 16,
   parameter int POST_STAGES = 3,
   parameter int CNT_W       = 32,
   parameter int ROW_W       = $clog2(SA_ROWS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             cfg_mode,
   input  logic [CNT_W-1:0]       cfg_nif_k_k,
   input  logic                   hold,
   output logic                   busy,
   output logic                   done,
   output logic                   start_err,
   output logic                   sa_en,
   output logic                   sa_reset,
   output logic                   ch_out_reset,
   output logic                   ch_out_en,
   output logic [ROW_W-1:0]       row_idx,
   output logic [POST_STAGES-1:0] stage_en,
   output logic [POST_STAGES-1:0] stage_reset,
   output logic                   sum_e_reset,
   output logic                   mult_array_mode,
   output logic                   fifo_en,
   output logic                   tile_end
);
   localparam int DW = $clog2(SA_SKEW + SA_ROWS + 1);
   localparam logic [DW-1:0] LAST = DW'(SA_SKEW + SA_ROWS);
   localparam logic [DW-1:0] LAST_M1 = DW'(SA_SKEW + SA_ROWS - 1);
   localparam logic [DW-1:0] SKEW = DW'(SA_SKEW);
   typedef enum logic [1:0] {IDLE, ACC, DRAIN, FLUSH} state_t;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       pix_q, pix_d, nkk_q, nkk_d;
   logic [3:0]             mode_q, mode_d;
   logic [DW-1:0]          drn_q, drn_d;
   logic [POST_STAGES:0]   en_q, en_d, end_q, end_d;
   logic [POST_STAGES-1:0] rst_q, rst_d;
   logic                   err_q, err_d;
   logic                   acc_last, drn_last, ch_raw, end_raw;
   // unmasked decode of the registered state; the post chains shift these
   always_comb begin
      acc_last = (state_q == ACC) && (pix_q == nkk_q);
      drn_last = (state_q == DRAIN) && (drn_q == LAST);
      ch_raw   = (state_q == DRAIN) && (drn_q >= SKEW) && (drn_q < LAST);
      end_raw  = (state_q == DRAIN) && (drn_q == LAST_M1);
   end
   // next state; hold freezes everything except the sticky start error
   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      nkk_d   = nkk_q;
      mode_d  = mode_q;
      drn_d   = drn_q;
      en_d    = en_q;
      end_d   = end_q;
      rst_d   = rst_q;
      err_d   = err_q | (start & busy);
      if (!hold) begin
         en_d  = {en_q[POST_STAGES-1:0], ch_raw};
         end_d = {end_q[POST_STAGES-1:0], end_raw};
         rst_d = POST_STAGES'({rst_q, drn_last});
         case (state_q)
            IDLE: if (start) begin
               state_d = ACC;
               pix_d   = '0;
               nkk_d   = cfg_nif_k_k;
               mode_d  = cfg_mode;
            end
            ACC: begin
               pix_d = pix_q + CNT_W'(1);
               if (acc_last) begin
                  state_d = DRAIN;
                  drn_d   = '0;
               end
            end
            DRAIN: begin
               drn_d = drn_q + DW'(1);
               if (drn_last) state_d = FLUSH;
            end
            default: if (end_q[POST_STAGES]) state_d = IDLE;
         endcase
      end
   end
   // state registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pix_q   <= '0;
         nkk_q   <= '0;
         mode_q  <= '0;
         drn_q   <= '0;
         en_q    <= '0;
         end_q   <= '0;
         rst_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         nkk_q   <= nkk_d;
         mode_q  <= mode_d;
         drn_q   <= drn_d;
         en_q    <= en_d;
         end_q   <= end_d;
         rst_q   <= rst_d;
         err_q   <= err_d;
      end
   end
   assign busy            = (state_q != IDLE);
   assign start_err       = err_q;
   assign sa_en           = !hold && ((state_q == ACC) || ((state_q == DRAIN) && (drn_q < LAST)));
   assign sa_reset        = !hold && drn_last;
   assign sum_e_reset     = !hold && drn_last;
   assign ch_out_reset    = !hold && acc_last;
   assign ch_out_en       = !hold && ch_raw;
   assign row_idx         = ch_out_en ? ROW_W'(drn_q - SKEW) : '0;
   assign stage_en        = hold ? '0 : en_q[POST_STAGES-1:0];
   assign stage_reset     = hold ? '0 : rst_q;
   assign fifo_en         = !hold && en_q[POST_STAGES];
   assign tile_end        = !hold && end_q[POST_STAGES];
   assign done            = tile_end;
   assign mult_array_mode = (mode_q == 4'd1) && stage_en[0];
endmodule
